seq_detect_param: RTL and testbench
===================================

# seq_detect_param

Parametrised serial bit-pattern detector: the generalised successor of the fixed 1011 Mealy/Moore, overlap/non-overlap detectors. The pattern, its length, the Mealy/Moore output style and the overlap policy are elaboration-time parameters. The block adds an input-enable qualifier and a saturating match counter with synchronous clear. It sits on a single-bit serial stream in the same clock domain as its producer.

## Interface
- `W`, 4, pattern length in bits; legal range 2..16.
- `PATTERN`, 4'b1011, W-bit pattern; `PATTERN[W-1]` is the first bit received.
- `OVERLAP`, 1, 1 = overlapping detection, 0 = non-overlapping.
- `MOORE`, 0, 1 = registered Moore output, 0 = combinational Mealy output.
- `CNT_W`, 8, match counter width.
- `clk` input 1: single clock; all state changes on the rising edge.
- `rst` input 1: asynchronous, active-low reset (asserted when 0).
- `en` input 1: when high, `x` is sampled on this edge.
- `x` input 1: serial data bit.
- `clr` input 1: synchronous clear of `match_cnt`.
- `y` output 1: match indication.
- `match_cnt` output CNT_W: saturating count of matches.

## Operation
- Progress state `k` is the length of the longest suffix of accepted bits that is a proper prefix of `PATTERN`, in the range 0..W-1. Moore mode adds a state `k = W` (MATCH).
- Transitions follow KMP. The next-state table is computed at elaboration by a constant function over `PATTERN`; there is no runtime pattern search.
- A match completes on a sampling edge with `en=1` when `k = W-1` and `x = PATTERN[0]`.
- Post-match state:
  - `OVERLAP=1`: `B`, the length of the longest proper border of `PATTERN`. For 1011, `B=1`.
  - `OVERLAP=0`: 0.
- Moore mode:
  - A completed match goes to MATCH.
  - From MATCH, the next state is computed as if the current state were the post-match state (`B` or 0).
- `en=0`:
  - State and `match_cnt` hold.
  - Mealy `y` is 0.
  - Moore `y` holds its value (it is a function of state only).
- Counter update on each edge, in priority order:
  1. `clr=1` sets `match_cnt` to 0. `clr` wins over a simultaneous match, and that match is not counted.
  2. Otherwise a completed match increments `match_cnt`.
  3. The counter saturates at 2^CNT_W-1 and never wraps.
- Parameter check: `W` outside 2..16 is an elaboration error (`$error` in an initial/generate check).

## Timing
- Reset values: `k=0`, `match_cnt=0`, Moore `y=0`, Mealy `y=0`. All take effect immediately on `rst` falling, independent of `clk`.
- Reset mid-pattern discards all partial progress. The first bit after release starts at `k=0`.
- Mealy `y`:
  - Combinational: `y = en & (k==W-1) & (x==PATTERN[0])`.
  - It is high during the cycle in which the completing bit is presented, before the edge that samples it.
- Moore `y`:
  - Registered: `y = (k==W)`.
  - It is high for the cycle after the edge that sampled the completing bit, i.e. one cycle later than Mealy.
- `match_cnt` increments on the same edge that samples the completing bit, in both modes.
- Back-to-back matches (e.g. pattern 111 with overlap) give Mealy `y` high on consecutive cycles and Moore `y` staying high (MATCH to MATCH).
- No throughput limit: one bit per cycle whenever `en=1`.

## Test plan
- Defaults (1011, overlap, Mealy), `en=1`, stream 1,0,1,1,0,1,0,1,1,0 -> `y` high while bit 4 and bit 9 are presented; `match_cnt=2` after bit 10.
- 1011, stream 1,0,1,1,0,1,1:
  - `OVERLAP=1` -> matches at bits 4 and 7, `match_cnt=2`.
  - `OVERLAP=0` -> match at bit 4 only, `match_cnt=1`.
  - With `MOORE=1`, `y` is high in the cycles after the edges sampling bits 4 and 7.
- `W=3`, `PATTERN=3'b111`, stream of six 1s:
  - Overlap -> matches at bits 3,4,5,6, Moore `y` held high across cycles 4-7, count 4.
  - Non-overlap -> matches at bits 3 and 6, count 2.
- `en` gaps: stream 1,0,1,1 with `en` low for 3 cycles between bits 2 and 3 (`x` toggling while low) -> exactly one match; Mealy `y` is 0 while `en` is low.
- Reset and clear:
  - `rst` low asynchronously after bits 1,0,1, then 1 -> no match; `match_cnt=0` immediately on `rst` falling.
  - `clr` asserted on the same edge as a match -> `match_cnt=0`.
- Saturation: `CNT_W=2`, five overlapping 111 matches -> `match_cnt` sticks at 3.

Source files
------------

// File: rtl/seq_detect_param.sv
// Parametrised serial bit-pattern detector: KMP next-state table built at elaboration,
// Mealy/Moore output selection, overlap policy, input enable and saturating match count.
module seq_detect_param #(
   parameter int unsigned  W       = 4,
   parameter logic [W-1:0] PATTERN = 4'b1011,
   parameter bit           OVERLAP = 1'b1,
   parameter bit           MOORE   = 1'b0,
   parameter int unsigned  CNT_W   = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             x,
   input  logic             clr,
   output logic             y,
   output logic [CNT_W-1:0] match_cnt
);

   localparam int unsigned SW    = $clog2(W + 1);
   localparam int unsigned NENT  = 2 ** (SW + 1);
   localparam int unsigned TBL_W = 2 * W * SW;

   // Bit i of the received sequence (i = 0 is the first bit on the wire)
   function automatic logic pat_bit(input int unsigned i);
      return PATTERN[W - 1 - i];
   endfunction

   // Longest proper border of the pattern
   function automatic int unsigned border_len();
      int unsigned best;
      logic        ok;
      best = 0;
      for (int unsigned len = 1; len < W; len++) begin
         ok = 1'b1;
         for (int unsigned j = 0; j < len; j++)
            if (pat_bit(j) != pat_bit(W - len + j)) ok = 1'b0;
         if (ok) best = len;
      end
      return best;
   endfunction

   // Longest suffix of (prefix of length k, then bit b) that is a prefix; W means match
   function automatic int unsigned step(input int unsigned k, input logic b);
      int unsigned best;
      int unsigned p;
      logic        ok;
      logic        t;
      best = 0;
      for (int unsigned len = 1; len <= k + 1; len++) begin
         ok = 1'b1;
         for (int unsigned j = 0; j < len; j++) begin
            p = k + 1 - len + j;
            t = (p == k) ? b : pat_bit(p);
            if (pat_bit(j) != t) ok = 1'b0;
         end
         if (ok) best = len;
      end
      return best;
   endfunction

   function automatic logic [TBL_W-1:0] build_tbl();
      logic [TBL_W-1:0] t;
      t = '0;
      for (int unsigned k = 0; k < W; k++) begin
         t[(2 * k) * SW +: SW]     = SW'(step(k, 1'b0));
         t[(2 * k + 1) * SW +: SW] = SW'(step(k, 1'b1));
      end
      return t;
   endfunction

   localparam logic [TBL_W-1:0] NXT_TBL  = build_tbl();
   localparam logic [SW-1:0]    MATCH_ST = SW'(W);
   localparam logic [SW-1:0]    POST_ST  = OVERLAP ? SW'(border_len()) : '0;

   if (W < 2 || W > 16) begin : g_bad_w
      $error("seq_detect_param: W must be in 2..16");
   end

   // Table indexed by {state, bit}; unused slots padded so any index is in range
   logic [SW-1:0] nxt_tbl [NENT];
   for (genvar i = 0; i < NENT; i++) begin : g_tbl
      if (i < int'(2 * W)) begin : g_used
         assign nxt_tbl[i] = NXT_TBL[i * SW +: SW];
      end else begin : g_pad
         assign nxt_tbl[i] = '0;
      end
   end

   logic [SW-1:0]    k_q, k_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [SW-1:0]    k_eff_c;
   logic [SW-1:0]    nxt_c;
   logic             match_c;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         k_q   <= '0;
         cnt_q <= '0;
      end else begin
         k_q   <= k_d;
         cnt_q <= cnt_d;
      end
   end

   // MATCH behaves like the post-match state when choosing the next state
   always_comb begin
      k_eff_c = (k_q == MATCH_ST) ? POST_ST : k_q;
      nxt_c   = nxt_tbl[{k_eff_c, x}];
      match_c = en & (nxt_c == MATCH_ST);
      k_d     = k_q;
      cnt_d   = cnt_q;
      if (en) begin
         if (match_c) k_d = MOORE ? MATCH_ST : POST_ST;
         else         k_d = nxt_c;
      end
      if (clr)                           cnt_d = '0;
      else if (match_c && cnt_q != '1)   cnt_d = cnt_q + CNT_W'(1'b1);
   end

   always_comb begin
      y = 1'b0;
      if (MOORE) y = (k_q == MATCH_ST);
      else       y = match_c;
   end

   assign match_cnt = cnt_q;

endmodule

// File: tb/tb_seq_detect_param.sv
// Directed bench for seq_detect_param: several parameterisations share one input stream,
// each output is compared against hand-derived expectations.
module tb_seq_detect_param;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic en  = 1'b0;
   logic x   = 1'b0;
   logic clr = 1'b0;

   logic       ya, yb, yc, yd, ye, yf;
   logic [7:0] ca, cb, cc, cd, ce;
   logic [1:0] cf;

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   // a: 1011 overlap Mealy, b: 1011 non-overlap Mealy, c: 1011 overlap Moore
   seq_detect_param u_a (.clk(clk), .rst(rst), .en(en), .x(x), .clr(clr), .y(ya), .match_cnt(ca));
   seq_detect_param #(.OVERLAP(1'b0)) u_b
      (.clk(clk), .rst(rst), .en(en), .x(x), .clr(clr), .y(yb), .match_cnt(cb));
   seq_detect_param #(.MOORE(1'b1)) u_c
      (.clk(clk), .rst(rst), .en(en), .x(x), .clr(clr), .y(yc), .match_cnt(cc));
   // d: 111 overlap Moore, e: 111 non-overlap Moore, f: 111 overlap Mealy with 2-bit count
   seq_detect_param #(.W(3), .PATTERN(3'b111), .MOORE(1'b1)) u_d
      (.clk(clk), .rst(rst), .en(en), .x(x), .clr(clr), .y(yd), .match_cnt(cd));
   seq_detect_param #(.W(3), .PATTERN(3'b111), .OVERLAP(1'b0), .MOORE(1'b1)) u_e
      (.clk(clk), .rst(rst), .en(en), .x(x), .clr(clr), .y(ye), .match_cnt(ce));
   seq_detect_param #(.W(3), .PATTERN(3'b111), .CNT_W(2)) u_f
      (.clk(clk), .rst(rst), .en(en), .x(x), .clr(clr), .y(yf), .match_cnt(cf));

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   // Present a bit mid-cycle; Mealy outputs are valid on return
   task automatic drive(input logic xb, input logic eb, input logic cb);
      @(negedge clk);
      x   = xb;
      en  = eb;
      clr = cb;
      #1;
   endtask

   // Let the sampling edge pass; registered outputs are valid on return
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      x   = 1'b0;
      en  = 1'b0;
      clr = 1'b0;
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
   endtask

   int cd_e [7] = '{0, 0, 1, 2, 3, 4, 5};
   int ce_e [7] = '{0, 0, 1, 1, 1, 2, 2};
   int cf_e [7] = '{0, 0, 1, 2, 3, 3, 3};

   initial begin
      logic [9:0] t1x, t1y;
      logic [6:0] t2x, t2ya, t2yb, t2yc, t3yf, t3yd, t3ye;
      logic [8:0] t4x, t4en, t4ya, t4yc, t4ca;

      // Reset state
      #2 rst = 1'b0;
      #1;
      check("rst ca", 32'(ca), 32'd0);
      check("rst ya", 32'(ya), 32'd0);
      check("rst yc", 32'(yc), 32'd0);
      check("rst yd", 32'(yd), 32'd0);
      check("rst cf", 32'(cf), 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b1;

      // Default config: matches while bits 4 and 9 are presented
      t1x = 10'b1011010110;
      t1y = 10'b0001000010;
      for (int i = 0; i < 10; i++) begin
         drive(t1x[9 - i], 1'b1, 1'b0);
         check($sformatf("t1 ya bit%0d", i + 1), 32'(ya), 32'(t1y[9 - i]));
         tick();
      end
      check("t1 ca", 32'(ca), 32'd2);

      // 1011 overlap vs non-overlap, Mealy vs Moore
      do_reset();
      t2x  = 7'b1011011;
      t2ya = 7'b0001001;
      t2yb = 7'b0001000;
      t2yc = 7'b0001001;
      for (int i = 0; i < 7; i++) begin
         drive(t2x[6 - i], 1'b1, 1'b0);
         check($sformatf("t2 ya bit%0d", i + 1), 32'(ya), 32'(t2ya[6 - i]));
         check($sformatf("t2 yb bit%0d", i + 1), 32'(yb), 32'(t2yb[6 - i]));
         tick();
         check($sformatf("t2 yc after%0d", i + 1), 32'(yc), 32'(t2yc[6 - i]));
      end
      check("t2 ca", 32'(ca), 32'd2);
      check("t2 cb", 32'(cb), 32'd1);
      check("t2 cc", 32'(cc), 32'd2);

      // 111 runs: back-to-back Moore, non-overlap, saturation at 3
      do_reset();
      t3yf = 7'b0011111;
      t3yd = 7'b0011111;
      t3ye = 7'b0010010;
      for (int i = 0; i < 7; i++) begin
         drive(1'b1, 1'b1, 1'b0);
         check($sformatf("t3 yf bit%0d", i + 1), 32'(yf), 32'(t3yf[6 - i]));
         tick();
         check($sformatf("t3 yd after%0d", i + 1), 32'(yd), 32'(t3yd[6 - i]));
         check($sformatf("t3 ye after%0d", i + 1), 32'(ye), 32'(t3ye[6 - i]));
         check($sformatf("t3 cd after%0d", i + 1), 32'(cd), 32'(cd_e[i]));
         check($sformatf("t3 ce after%0d", i + 1), 32'(ce), 32'(ce_e[i]));
         check($sformatf("t3 cf after%0d", i + 1), 32'(cf), 32'(cf_e[i]));
      end

      // Enable gaps with x toggling; Moore output holds while en is low
      do_reset();
      t4x  = 9'b101011110;
      t4en = 9'b110001010;
      t4ya = 9'b000000010;
      t4yc = 9'b000000011;
      t4ca = 9'b000000011;
      for (int i = 0; i < 9; i++) begin
         drive(t4x[8 - i], t4en[8 - i], 1'b0);
         check($sformatf("t4 ya step%0d", i + 1), 32'(ya), 32'(t4ya[8 - i]));
         tick();
         check($sformatf("t4 yc step%0d", i + 1), 32'(yc), 32'(t4yc[8 - i]));
         check($sformatf("t4 ca step%0d", i + 1), 32'(ca), 32'(t4ca[8 - i]));
      end

      // Asynchronous reset mid-pattern with a non-zero count
      do_reset();
      t2x = 7'b1011010;
      for (int i = 0; i < 6; i++) begin
         drive(t2x[6 - i], 1'b1, 1'b0);
         tick();
      end
      check("t5 ca pre", 32'(ca), 32'd1);
      #2 rst = 1'b0;
      #1;
      check("t5 ca async", 32'(ca), 32'd0);
      check("t5 cc async", 32'(cc), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      drive(1'b1, 1'b1, 1'b0);
      check("t5 ya after rst", 32'(ya), 32'd0);
      tick();
      check("t5 ca after rst", 32'(ca), 32'd0);

      // Clear on the same edge as a match wins and drops that match
      do_reset();
      t2x = 7'b1011011;
      for (int i = 0; i < 6; i++) begin
         drive(t2x[6 - i], 1'b1, 1'b0);
         tick();
      end
      check("t6 ca pre", 32'(ca), 32'd1);
      drive(1'b1, 1'b1, 1'b1);
      check("t6 ya clr", 32'(ya), 32'd1);
      tick();
      check("t6 ca clr", 32'(ca), 32'd0);
      check("t6 cc clr", 32'(cc), 32'd0);
      drive(1'b0, 1'b1, 1'b0);
      tick();
      drive(1'b1, 1'b1, 1'b0);
      tick();
      drive(1'b1, 1'b1, 1'b0);
      tick();
      check("t6 ca resume", 32'(ca), 32'd1);
      check("t6 cc resume", 32'(cc), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
